// File: rtl/hdmi_aux_pkg.sv
// Shared definitions for the HDMI aux packet scheduler: source indices,
// packet geometry, FSM encoding and small helpers.
package hdmi_aux_pkg;

  localparam logic [1:0] SRC_A = 2'd0;  // audio sample
  localparam logic [1:0] SRC_B = 2'd1;  // clock regeneration
  localparam logic [1:0] SRC_C = 2'd2;  // AVI infoframe
  localparam logic [1:0] SRC_D = 2'd3;  // audio infoframe

  localparam int PACKET_SLOTS       = 32;
  localparam int ISLAND_OVH_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ISLAND  = 2'd2
  } sched_state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/hdmi_aux_rr_arbiter.sv
// Combinational 4-way round-robin arbiter with optional fixed priority for
// source A. Search starts at ptr_i; the caller owns and advances the pointer.
module hdmi_aux_rr_arbiter
  import hdmi_aux_pkg::*;
#(
  parameter bit PRIO_A = 1'b1
) (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       none_o
);

  logic [1:0] cand;

  // Pick A outright when it has priority, else first requester from ptr_i.
  always_comb begin
    gnt_o  = 4'b0000;
    idx_o  = SRC_A;
    none_o = 1'b1;
    cand   = ptr_i;
    if (PRIO_A && req_i[SRC_A]) begin
      gnt_o[SRC_A] = 1'b1;
      idx_o        = SRC_A;
      none_o       = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr_i + 2'(k);
        if (none_o && req_i[cand] && !(PRIO_A && cand == SRC_A)) begin
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
          none_o      = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_aux_scheduler.sv
// HDMI data-island scheduler: sizes each island to the remaining blanking
// room, requests it from the video sequencer and arbitrates the owner of
// every 32-slot packet among four aux sources.
// Optional build macro HDMI_AUX_SCHED_STATS_EN adds per-frame packet/null
// statistics outputs.
module hdmi_aux_scheduler
  import hdmi_aux_pkg::*;
#(
  parameter int MAX_PACKETS    = 4,
  parameter int ISLAND_OVH     = ISLAND_OVH_DEFAULT,
  parameter int MIN_CTRL       = 12,
  parameter int AUDIO_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ready,
  input  logic [11:0] blank_cycles_left,
  input  logic        ae,
  input  logic [4:0]  slot,
  input  logic        packet_end,
  input  logic        frame_end,
  output logic        aux_request,
  output logic [4:0]  island_len,
  output logic [3:0]  enable,
  output logic [1:0]  sel,
  output logic        null_packet
`ifdef HDMI_AUX_SCHED_STATS_EN
  ,
  output logic [15:0] stat_packets,
  output logic [15:0] stat_nulls
`endif
);

  localparam logic [12:0] BASE_CYC  = 13'(ISLAND_OVH + MIN_CTRL);
  localparam logic [4:0]  MAX_LEN   = 5'(MAX_PACKETS);
  localparam logic [4:0]  LAST_SLOT = 5'(PACKET_SLOTS - 1);

  sched_state_e state_q, state_d;
  logic [4:0]   len_q, len_d;
  logic [4:0]   pkt_q, pkt_d;
  logic [3:0]   grant_q, grant_d;
  logic [3:0]   used_q, used_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   pend_ptr_q, pend_ptr_d;
  logic         null_q, null_d;

  logic [3:0]   arb_req, arb_gnt;
  logic [1:0]   arb_idx;
  logic         arb_none;

  logic [4:0]   n_pk, fit;
  logic [12:0]  room, need;
  logic [7:0]   kmax;
  logic         too_short, pkt_done, last_pkt;

  // Pointer lands just after the winner; a priority win by A leaves it alone
  // and, in priority mode, the rotation covers only B..D.
  function automatic logic [1:0] ptr_after(input logic [1:0] win, input logic [1:0] cur);
    if (AUDIO_PRIORITY != 0) begin
      if (win == SRC_A) return cur;
      if (win == SRC_D) return SRC_B;
    end
    return win + 2'd1;
  endfunction

  // Island sizing: how many packets fit in the blanking still available.
  always_comb begin
    n_pk = {2'b00, popcount4(ready)};
    if (n_pk > MAX_LEN) n_pk = MAX_LEN;
    room      = ({1'b0, blank_cycles_left} >= BASE_CYC) ? ({1'b0, blank_cycles_left} - BASE_CYC) : 13'd0;
    kmax      = 8'(room >> 5);
    fit       = ({3'b000, n_pk} <= kmax) ? n_pk : kmax[4:0];
    need      = BASE_CYC + {3'b000, len_q, 5'b00000};
    too_short = ({1'b0, blank_cycles_left} < need);
  end

  assign pkt_done = packet_end && (slot == LAST_SLOT);
  assign last_pkt = (pkt_q == len_q - 5'd1);
  // Inside an island, sources already served must re-arm before winning again.
  assign arb_req  = (state_q == ST_ISLAND) ? (ready & ~used_q) : ready;

  hdmi_aux_rr_arbiter #(
    .PRIO_A (AUDIO_PRIORITY != 0)
  ) u_arb (
    .req_i  (arb_req),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .none_o (arb_none)
  );

  // Next-state logic for the request/island sequence and packet ownership.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pkt_d      = pkt_q;
    grant_d    = grant_q;
    used_d     = used_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    pend_ptr_d = pend_ptr_q;
    null_d     = null_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = 4'b0000;
        sel_d   = SRC_A;
        null_d  = 1'b0;
        if (!ae && fit != 5'd0) begin
          state_d    = ST_REQUEST;
          len_d      = fit;
          pkt_d      = 5'd0;
          used_d     = 4'b0000;
          grant_d    = arb_gnt;
          sel_d      = arb_idx;
          // Pointer advance is held back until the island actually starts.
          pend_ptr_d = ptr_after(arb_idx, ptr_q);
        end
      end
      ST_REQUEST: begin
        if (ae) begin
          state_d = ST_ISLAND;
          ptr_d   = pend_ptr_q;
          used_d  = grant_q;
        end else if (too_short) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          sel_d   = SRC_A;
        end
      end
      ST_ISLAND: begin
        // A non-owner seen idle is re-armed for this island.
        used_d = used_q & (ready | grant_q);
        if (pkt_done) begin
          if (last_pkt) begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            sel_d   = SRC_A;
            null_d  = 1'b0;
          end else begin
            pkt_d = pkt_q + 5'd1;
            if (arb_none) begin
              grant_d = 4'b0000;
              sel_d   = SRC_A;
              null_d  = 1'b1;
            end else begin
              grant_d = arb_gnt;
              sel_d   = arb_idx;
              null_d  = 1'b0;
              ptr_d   = ptr_after(arb_idx, ptr_q);
              used_d  = used_d | arb_gnt;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state registers; reset clears every output-driving register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= 5'd0;
      pkt_q      <= 5'd0;
      grant_q    <= 4'b0000;
      used_q     <= 4'b0000;
      sel_q      <= SRC_A;
      ptr_q      <= SRC_B;
      pend_ptr_q <= SRC_B;
      null_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pkt_q      <= pkt_d;
      grant_q    <= grant_d;
      used_q     <= used_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      pend_ptr_q <= pend_ptr_d;
      null_q     <= null_d;
    end
  end

  // Grant is prepared during REQUEST but only shown while island data flows.
  assign aux_request = (state_q == ST_REQUEST) && !ae;
  assign island_len  = len_q;
  assign enable      = ae ? grant_q : 4'b0000;
  assign sel         = sel_q;
  assign null_packet = ae && null_q;

`ifdef HDMI_AUX_SCHED_STATS_EN
  logic [15:0] pk_cnt_q, nl_cnt_q, stat_pk_q, stat_nl_q;
  logic        grant_evt, null_evt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign grant_evt = (state_q == ST_REQUEST && ae) ||
                     (state_q == ST_ISLAND && pkt_done && !last_pkt && !arb_none);
  assign null_evt  = (state_q == ST_ISLAND && pkt_done && !last_pkt && arb_none);

  // Per-frame counters; frame_end publishes them and starts the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_cnt_q  <= 16'd0;
      nl_cnt_q  <= 16'd0;
      stat_pk_q <= 16'd0;
      stat_nl_q <= 16'd0;
    end else if (frame_end) begin
      stat_pk_q <= pk_cnt_q;
      stat_nl_q <= nl_cnt_q;
      pk_cnt_q  <= {15'd0, grant_evt};
      nl_cnt_q  <= {15'd0, null_evt};
    end else begin
      pk_cnt_q  <= sat_inc(pk_cnt_q, grant_evt);
      nl_cnt_q  <= sat_inc(nl_cnt_q, null_evt);
    end
  end

  assign stat_packets = stat_pk_q;
  assign stat_nulls   = stat_nl_q;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_hdmi_aux_scheduler.sv
// Randomized bench for hdmi_aux_scheduler acting as the video sequencer;
// expected behaviour comes from a packet-level reference model.
module tb_hdmi_aux_scheduler;

  localparam int MAXP = 4;
  localparam int OVH  = 12;
  localparam int MINC = 12;
  localparam int AP   = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ready;
  logic [11:0] blank_cycles_left;
  logic        ae;
  logic [4:0]  slot;
  logic        packet_end;
  logic        frame_end;
  logic        aux_request;
  logic [4:0]  island_len;
  logic [3:0]  enable;
  logic [1:0]  sel;
  logic        null_packet;
`ifdef HDMI_AUX_SCHED_STATS_EN
  logic [15:0] stat_packets;
  logic [15:0] stat_nulls;
`endif

  hdmi_aux_scheduler #(
    .MAX_PACKETS    (MAXP),
    .ISLAND_OVH     (OVH),
    .MIN_CTRL       (MINC),
    .AUDIO_PRIORITY (AP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ready             (ready),
    .blank_cycles_left (blank_cycles_left),
    .ae                (ae),
    .slot              (slot),
    .packet_end        (packet_end),
    .frame_end         (frame_end),
    .aux_request       (aux_request),
    .island_len        (island_len),
    .enable            (enable),
    .sel               (sel),
    .null_packet       (null_packet)
`ifdef HDMI_AUX_SCHED_STATS_EN
    ,
    .stat_packets      (stat_packets),
    .stat_nulls        (stat_nulls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit fe_rand  = 1'b1;

  // Reference model state: round-robin pointer and per-island "already served" set.
  int         m_ptr;
  logic [3:0] m_used;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Largest packet count whose island plus overheads fits in the blanking.
  function automatic int m_fit(input logic [3:0] rdy, input int blank);
    int n;
    n = $countones(rdy);
    if (n > MAXP) n = MAXP;
    for (int k = n; k >= 1; k--)
      if (OVH + 32 * k + MINC <= blank) return k;
    return 0;
  endfunction

  // Owner choice: A first when prioritised, else first eligible from the pointer.
  function automatic int m_pick(input logic [3:0] elig, input int ptr, output int nptr);
    nptr = ptr;
    if (AP != 0 && elig[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (!(AP != 0 && c == 0) && elig[c]) begin
        if (AP != 0) nptr = (c == 3) ? 1 : c + 1;
        else         nptr = (c + 1) % 4;
        return c;
      end
    end
    return -1;
  endfunction

  function automatic logic [6:0] m_out(input int owner);
    if (owner < 0) return 7'b1000000;
    return {1'b0, 2'(owner), 4'(1 << owner)};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    ready = 4'b0; blank_cycles_left = 12'd0; ae = 1'b0;
    slot = 5'd0; packet_end = 1'b0; frame_end = 1'b0;
    #1;
    check("rst_out", {aux_request, island_len, enable, sel, null_packet}, 0);
    tick(); tick();
    reset_n = 1'b1;
    m_ptr  = 1;
    m_used = 4'b0;
    tick();
  endtask

  // One island attempt: request, optional withdrawal, then packet-by-packet ownership.
  task automatic run_island(input logic [3:0] rdy, input logic [3:0] rdy_mid,
                            input bit rand_mid, input int blank, input bit withdraw);
    int fit, first, nptr, owner, nxt;
    logic [3:0] elig;
    ready = rdy; blank_cycles_left = 12'(blank);
    ae = 1'b0; packet_end = 1'b0; slot = 5'd0; frame_end = 1'b0;
    fit = m_fit(rdy, blank);
    tick();
    if (fit == 0) begin
      check("no_req", {aux_request, enable}, 0);
      blank_cycles_left = 12'd0;
      return;
    end
    first = m_pick(rdy, m_ptr, nptr);
    check("req", aux_request, 1);
    check("len", island_len, fit);
    check("pre_sel", sel, first);
    check("pre_en", enable, 0);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("req_hold", aux_request, 1);
    end
    if (withdraw) begin
      blank_cycles_left = 12'(OVH + MINC + 26);
      tick();
      check("wd_req", aux_request, 0);
      tick();
      check("wd_idle", {aux_request, enable, null_packet}, 0);
      blank_cycles_left = 12'd0;
      return;
    end
    m_ptr  = nptr;
    owner  = first;
    m_used = 4'b0;
    m_used[first] = 1'b1;
    for (int p = 0; p < fit; p++) begin
      for (int s = 0; s < 32; s++) begin
        ae = 1'b1; slot = 5'(s); packet_end = (s == 31);
        frame_end = fe_rand && ($urandom_range(0, 15) == 0);
        if (rand_mid && (s == 8 || s == 24)) ready = 4'($urandom_range(0, 15));
        else if (!rand_mid && s == 16)       ready = rdy_mid;
        #1;
        if (p == 0 && s == 0) check("req_drop", aux_request, 0);
        check("pkt", {null_packet, sel, enable}, m_out(owner));
        nxt = owner;
        if (s == 31 && p < fit - 1) begin
          elig = ready & ~m_used;
          nxt  = m_pick(elig, m_ptr, nptr);
          m_ptr = nptr;
        end
        for (int i = 0; i < 4; i++)
          if (!ready[i] && owner != i) m_used[i] = 1'b0;
        if (s == 31 && p < fit - 1) begin
          owner = nxt;
          if (nxt >= 0) m_used[nxt] = 1'b1;
        end
        tick();
      end
    end
    ae = 1'b0; packet_end = 1'b0; frame_end = 1'b0; blank_cycles_left = 12'd0;
    #1;
    check("end", {aux_request, null_packet, sel, enable}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single audio packet with plenty of room.
    run_island(4'b0001, 4'b0001, 1'b0, 200, 1'b0);
    // All sources ready, room for two: A then B, pointer moves on to C.
    run_island(4'b1111, 4'b1111, 1'b0, 100, 1'b0);
    run_island(4'b1110, 4'b1110, 1'b0, 60, 1'b0);

    // Fresh pointer: B, C, D rotation over three one-packet islands.
    do_reset();
    for (int i = 0; i < 3; i++) run_island(4'b1110, 4'b1110, 1'b0, 60, 1'b0);

    // Second packet loses its only candidate: null packet.
    run_island(4'b0011, 4'b0001, 1'b0, 100, 1'b0);

    // Blanking shrinks during REQUEST: withdrawal without a grant.
    run_island(4'b0001, 4'b0001, 1'b0, 100, 1'b1);
    run_island(4'b0110, 4'b0110, 1'b0, 100, 1'b0);

    // Asynchronous reset while an island is in progress.
    ready = 4'b0001; blank_cycles_left = 12'd200; ae = 1'b0;
    tick();
    ae = 1'b1; slot = 5'd0; tick();
    slot = 5'd1; #1;
    check("mid_en", enable, 4'b0001);
    reset_n = 1'b0;
    #1;
    check("rst_mid", {aux_request, island_len, enable, sel, null_packet}, 0);
    ae = 1'b0; ready = 4'b0; blank_cycles_left = 12'd0;
    tick();
    reset_n = 1'b1; m_ptr = 1; m_used = 4'b0;
    tick();

`ifdef HDMI_AUX_SCHED_STATS_EN
    do_reset();
    fe_rand = 1'b0;
    run_island(4'b0011, 4'b0011, 1'b0, 100, 1'b0);
    run_island(4'b0011, 4'b0001, 1'b0, 100, 1'b0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("stat_pk", stat_packets, 3);
    check("stat_nl", stat_nulls, 1);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("stat_clr", {stat_packets, stat_nulls}, 0);
    fe_rand = 1'b1;
`endif

    // Randomized islands with changing ready and occasional withdrawals.
    for (int i = 0; i < 60; i++) begin
      run_island(4'($urandom_range(0, 15)), 4'b0000, 1'b1,
                 int'($urandom_range(0, 200)), ($urandom_range(0, 7) == 0));
      tick();
      check("gap", {aux_request, enable}, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
